// File: rtl/pri_encode_rr.sv
// Registered N-input priority encoder/arbiter, fixed or round-robin priority, valid/ready output.
// Define PRI_RR_LOCK_EN to add the `lock` input, which regrants the index just transferred.
module pri_encode_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
`ifdef PRI_RR_LOCK_EN
  input  logic         lock,
`endif
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_valid
);

  logic         valid_q;
  logic [W-1:0] idx_q, ptr_q;
  logic [N-1:0] onehot_q;

  logic         slot, lock_hit, rr_hit;
  logic [W-1:0] fix_idx, rr_idx, rr_cand, win_idx;
  logic [N-1:0] win_onehot;

  assign slot = !valid_q || out_ready;

`ifdef PRI_RR_LOCK_EN
  // A locked transfer keeps the same requester as long as it is still asking.
  assign lock_hit = valid_q && out_ready && lock && req[idx_q];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) fix_idx = W'(i);

    // Descending search from ptr-1, wrapping through N-1 down to ptr itself.
    rr_idx  = '0;
    rr_hit  = 1'b0;
    rr_cand = '0;
    for (int k = 1; k <= N; k++) begin
      rr_cand = W'((int'(ptr_q) + N - k) % N);
      if (!rr_hit && req[rr_cand]) begin
        rr_idx = rr_cand;
        rr_hit = 1'b1;
      end
    end

    if (lock_hit)  win_idx = idx_q;
    else if (mode) win_idx = rr_idx;
    else           win_idx = fix_idx;
    win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else if (slot) begin
      if (|req) begin
        valid_q  <= 1'b1;
        idx_q    <= win_idx;
        onehot_q <= win_onehot;
        if (!lock_hit) ptr_q <= win_idx;
      end else begin
        valid_q  <= 1'b0;
        idx_q    <= '0;
        onehot_q <= '0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;

endmodule

// File: tb/tb_pri_encode_rr.sv
// Self-checking bench for pri_encode_rr: directed cases plus randomized traffic vs. a behavioural model.
module tb_pri_encode_rr;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode, out_ready, lock;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_valid;

  pri_encode_rr #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
`ifdef PRI_RR_LOCK_EN
    .lock(lock),
`endif
    .out_ready(out_ready), .out_idx(out_idx), .out_onehot(out_onehot), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int m_valid = 0, m_idx = 0, m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference: apply the arbitration rules to the inputs present at this edge.
  task automatic model_step();
    int win;
    bit xfer;
    if (m_valid == 0 || out_ready) begin
      xfer = (m_valid != 0) && out_ready;
      if (req == 0) begin
        m_valid = 0; m_idx = 0;
      end else begin
        win = -1;
`ifdef PRI_RR_LOCK_EN
        if (xfer && lock && req[m_idx]) win = m_idx;
`endif
        if (win < 0) begin
          if (!mode) begin
            for (int i = N-1; i >= 0; i--) if (win < 0 && req[i]) win = i;
          end else begin
            for (int off = 1; off <= N; off++)
              if (win < 0 && req[(m_ptr - off + N) % N]) win = (m_ptr - off + N) % N;
          end
          m_ptr = win;
        end
        m_valid = 1; m_idx = win;
      end
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"},  32'(out_valid),  32'(m_valid));
    chk({tag, ".idx"},    32'(out_idx),    32'(m_idx));
    chk({tag, ".onehot"}, 32'(out_onehot), (m_valid != 0) ? (32'd1 << m_idx) : 32'd0);
  endtask

  // Called at a negedge: drive, clock, compare, return at the next negedge.
  task automatic cyc(input logic [N-1:0] r, input logic md, input logic rdy, input logic lk,
                     input string tag);
    req = r; mode = md; out_ready = rdy; lock = lk;
    @(posedge clk);
    model_step();
    #1 check_out(tag);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"},  32'(out_valid),  0);
    chk({tag, ".idx"},    32'(out_idx),    0);
    chk({tag, ".onehot"}, 32'(out_onehot), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 check_zero("rst_async");
    m_valid = 0; m_idx = 0; m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] fix_req [6] = '{8'h00, 8'h08, 8'h04, 8'h0A, 8'h06, 8'h03};
  int           fix_vld [6] = '{0, 1, 1, 1, 1, 1};
  int           fix_idx [6] = '{0, 3, 2, 3, 2, 1};
  int           rr_exp  [6] = '{7, 4, 0, 7, 4, 0};
`ifdef PRI_RR_LOCK_EN
  int           lk_exp  [4] = '{4, 4, 4, 0};
`else
  int           lk_exp  [4] = '{4, 0, 4, 0};
`endif

  initial begin
    rst_n = 1'b0; req = 8'hFF; mode = 1'b0; out_ready = 1'b1; lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("reset");
    end
    rst_n = 1'b1;
    cyc(8'hFF, 0, 1, 0, "post_rst");
    chk("post_rst.idx7", 32'(out_idx), 7);
    chk("post_rst.oh80", 32'(out_onehot), 32'h80);

    for (int i = 0; i < 6; i++) begin
      cyc(fix_req[i], 0, 1, 0, "fixed");
      chk("fixed.vld_exp", 32'(out_valid), 32'(fix_vld[i]));
      chk("fixed.idx_exp", 32'(out_idx), 32'(fix_idx[i]));
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(8'h91, 1, 1, 0, "rr");
      chk("rr.idx_exp", 32'(out_idx), 32'(rr_exp[i]));
    end

    do_reset();
    cyc(8'h05, 1, 0, 0, "bp_grant");
    for (int i = 0; i < 3; i++) begin
      cyc(8'h01, 1, 0, 0, "bp_stall");
      chk("bp.hold2", 32'(out_idx), 2);
    end
    cyc(8'h01, 1, 1, 0, "bp_xfer");
    chk("bp.next0", 32'(out_idx), 0);

    do_reset();
    cyc(8'h81, 1, 1, 0, "msw_rr");
    chk("msw.rr7", 32'(out_idx), 7);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h81, 0, 1, 0, "msw_fix");
      chk("msw.fix7", 32'(out_idx), 7);
    end
    cyc(8'h81, 1, 1, 0, "msw_back");
    chk("msw.rr0", 32'(out_idx), 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(8'h11, 1, 1, (i < 3) ? 1'b1 : 1'b0, "lock");
      chk("lock.idx_exp", 32'(out_idx), 32'(lk_exp[i]));
    end

    // Reset in the middle of a stall drops the pending grant and restarts ptr.
    cyc(8'h0F, 1, 0, 0, "mid_grant");
    cyc(8'h0F, 1, 0, 0, "mid_stall");
    #2 do_reset();
    cyc(8'hFF, 1, 1, 0, "mid_after");
    chk("mid.idx7", 32'(out_idx), 7);

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 2) == 0) r = N'(1) << $urandom_range(0, N-1);
      cyc(r, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
